// File: rtl/ext_mem_pkg.sv
// Shared constants, helpers and parameter legality check for the external
// SRAM controller (CPU word split into narrow RAM beats).
package ext_mem_pkg;

  // Direction of the current CPU access, taken straight from cpu_rnw.
  typedef enum logic {
    ACC_WRITE = 1'b0,
    ACC_READ  = 1'b1
  } acc_dir_e;

  localparam int CPB_MIN = 2;
  localparam int CPB_MAX = 8;

  // Ceiling log2 with a bounded loop so it stays a clean constant function.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width helper: a counter always needs at least one bit.
  function automatic int clog2_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  // Number of RAM beats per CPU word.
  function automatic int calc_n(input int dsize, input int rsize);
    return dsize / rsize;
  endfunction

  // Width of the beat field appended to the RAM address.
  function automatic int calc_log2n(input int dsize, input int rsize);
    return clog2_min1(calc_n(dsize, rsize));
  endfunction

  // Clock cycles in one complete CPU access.
  function automatic int calc_total(input int dsize, input int rsize,
                                    input int cpb, input int reg_last);
    return calc_n(dsize, rsize) * cpb + reg_last;
  endfunction

  // True when the parameter set describes a buildable controller.
  function automatic bit params_legal(input int dsize, input int rsize,
                                      input int asize, input int rasize,
                                      input int cpb, input int reg_last);
    bit ok;
    ok = 1'b1;
    if (rsize <= 0 || dsize < rsize) ok = 1'b0;
    else if ((dsize % rsize) != 0) ok = 1'b0;
    else begin
      if (rasize <= calc_log2n(dsize, rsize)) ok = 1'b0;
      if (asize < rasize - calc_log2n(dsize, rsize)) ok = 1'b0;
    end
    if (cpb < CPB_MIN || cpb > CPB_MAX) ok = 1'b0;
    if (reg_last != 0 && reg_last != 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/ext_mem_ctrl_if.sv
// CPU-side and RAM-side signal bundle of the external SRAM controller.
// Handshake: the CPU holds ext_cs_b low (with address, direction and write
// data stable) until it samples cpu_clken high on a rising clock edge; that
// edge completes the access and read data on ext_dout is valid in that same
// clken-high cycle. If ext_cs_b is still low on the following cycle a new
// access begins immediately.
interface ext_mem_ctrl_if #(
  parameter int DSIZE  = 32,
  parameter int RSIZE  = 16,
  parameter int ASIZE  = 20,
  parameter int RASIZE = 18
);
  logic              ext_cs_b;
  logic              cpu_rnw;
  logic              cpu_clken;
  logic [ASIZE-1:0]  cpu_addr;
  logic [DSIZE-1:0]  cpu_dout;
  logic [DSIZE-1:0]  ext_dout;
  logic              ram_cs_b;
  logic              ram_oe_b;
  logic              ram_we_b;
  logic [RASIZE-1:0] ram_addr;
  logic [RSIZE-1:0]  ram_data_in;
  logic [RSIZE-1:0]  ram_data_out;
  logic              ram_data_oe;

  // Environment side: the CPU core plus the SRAM pads.
  modport master (
    output ext_cs_b, cpu_rnw, cpu_addr, cpu_dout, ram_data_in,
    input  cpu_clken, ext_dout, ram_cs_b, ram_oe_b, ram_we_b, ram_addr,
           ram_data_out, ram_data_oe
  );

  // Controller side.
  modport slave (
    input  ext_cs_b, cpu_rnw, cpu_addr, cpu_dout, ram_data_in,
    output cpu_clken, ext_dout, ram_cs_b, ram_oe_b, ram_we_b, ram_addr,
           ram_data_out, ram_data_oe
  );
endinterface

// File: rtl/ext_mem_seq.sv
// Access sequencer: cycle/phase/beat counters and the flop-driven RAM write
// strobe. The counters are exported so checkers can observe the sequence.
module ext_mem_seq
  import ext_mem_pkg::*;
#(
  parameter int N        = 2,
  parameter int CPB      = 2,
  parameter int REG_LAST = 0,
  parameter int BW       = 1,
  localparam int PW      = clog2_min1(CPB),
  localparam int CW      = clog2_min1(N * CPB + REG_LAST)
) (
  input  logic          clock_i,
  input  logic          reset_b_i,
  input  logic          ext_cs_b_i,
  input  logic          cpu_rnw_i,
  output logic [BW-1:0] beat_o,
  output logic [PW-1:0] phase_o,
  output logic [CW-1:0] cycle_o,
  output logic          last_cycle_o,
  output logic          beat_end_o,
  output logic          ram_we_b_o
);

  localparam int TOTAL       = N * CPB + REG_LAST;
  localparam int DATA_CYCLES = N * CPB;
  localparam logic [CW-1:0] LAST_C      = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DATA_LAST_C = CW'(DATA_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(CPB - 1);
  localparam logic          HAS_EXTRA   = (REG_LAST != 0);

  logic [CW-1:0] cycle_q, cycle_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          we_b_q, we_b_d;
  logic          active;
  logic          extra_d;
  logic          extra_q;

  // Next-state for the counters: run while selected or mid-access, hold
  // phase/beat through the registered-read extra cycle.
  always_comb begin
    active  = !ext_cs_b_i || (cycle_q != '0);
    cycle_d = cycle_q;
    phase_d = phase_q;
    beat_d  = beat_q;
    if (active) begin
      if (cycle_q == LAST_C) begin
        cycle_d = '0;
        phase_d = '0;
        beat_d  = '0;
      end else begin
        cycle_d = cycle_q + 1'b1;
        if (cycle_q != DATA_LAST_C) begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            beat_d  = beat_q + 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
    end
  end

  // Write strobe is decided one cycle ahead so it can come straight from a
  // flop: low for every non-setup phase of a write beat, never in the extra
  // read cycle, and high as soon as the CPU is not selecting a write.
  always_comb begin
    extra_d = HAS_EXTRA && (cycle_d == LAST_C);
    we_b_d  = !(!ext_cs_b_i && !cpu_rnw_i && (phase_d != '0) && !extra_d);
  end

  // Counter and strobe registers; reset abandons any access in flight.
  always_ff @(posedge clock_i) begin
    if (!reset_b_i) begin
      cycle_q <= '0;
      phase_q <= '0;
      beat_q  <= '0;
      we_b_q  <= 1'b1;
    end else begin
      cycle_q <= cycle_d;
      phase_q <= phase_d;
      beat_q  <= beat_d;
      we_b_q  <= we_b_d;
    end
  end

  // Observable state and per-cycle qualifiers for the datapath.
  always_comb begin
    extra_q      = HAS_EXTRA && (cycle_q == LAST_C);
    beat_o       = beat_q;
    phase_o      = phase_q;
    cycle_o      = cycle_q;
    last_cycle_o = (cycle_q == LAST_C);
    beat_end_o   = active && (phase_q == PHASE_LAST) && !extra_q;
    ram_we_b_o   = we_b_q;
  end

endmodule

// File: rtl/ext_mem_ctrl.sv
// External SRAM controller: splits one CPU word access into N narrow RAM
// beats (least-significant first), stalls the CPU until the final cycle and
// assembles read data from per-beat lanes.
module ext_mem_ctrl
  import ext_mem_pkg::*;
#(
  parameter int DSIZE    = 32,
  parameter int RSIZE    = 16,
  parameter int ASIZE    = 20,
  parameter int RASIZE   = 18,
  parameter int CPB      = 2,
  parameter int REG_LAST = 0
) (
  input  logic           clock,
  input  logic           reset_b,
  ext_mem_ctrl_if.slave  bus
);

  localparam int N     = calc_n(DSIZE, RSIZE);
  localparam int LOG2N = calc_log2n(DSIZE, RSIZE);
  localparam int TOTAL = calc_total(DSIZE, RSIZE, CPB, REG_LAST);
  localparam int PW    = clog2_min1(CPB);
  localparam int CW    = clog2_min1(TOTAL);
  localparam logic [LOG2N-1:0] BEAT_LAST = LOG2N'(N - 1);

  if (!params_legal(DSIZE, RSIZE, ASIZE, RASIZE, CPB, REG_LAST)) begin : g_param_check
    $error("ext_mem_ctrl: illegal DSIZE/RSIZE/ASIZE/RASIZE/CPB/REG_LAST combination");
  end

  logic [LOG2N-1:0] beat;
  logic [PW-1:0]    phase;
  logic [CW-1:0]    cycle;
  logic             last_cycle;
  logic             beat_end;
  logic             we_b;
  logic             capture;
  acc_dir_e         dir;
  logic [RSIZE-1:0] lane_q [N];
  logic [DSIZE-1:0] rdata;
  logic [RSIZE-1:0] wdata;
  logic             unused_bits;

  ext_mem_seq #(
    .N        (N),
    .CPB      (CPB),
    .REG_LAST (REG_LAST),
    .BW       (LOG2N)
  ) u_seq (
    .clock_i      (clock),
    .reset_b_i    (reset_b),
    .ext_cs_b_i   (bus.ext_cs_b),
    .cpu_rnw_i    (bus.cpu_rnw),
    .beat_o       (beat),
    .phase_o      (phase),
    .cycle_o      (cycle),
    .last_cycle_o (last_cycle),
    .beat_end_o   (beat_end),
    .ram_we_b_o   (we_b)
  );

  // Upper CPU address bits are outside the RAM; phase/cycle are only exported
  // for observation.
  assign unused_bits = ^{bus.cpu_addr, phase, cycle};

  assign dir = acc_dir_e'(bus.cpu_rnw);

  // Stall until the final cycle; during reset the enable tracks ext_cs_b.
  assign bus.cpu_clken   = bus.ext_cs_b | (reset_b & last_cycle);
  assign bus.ram_cs_b    = bus.ext_cs_b;
  assign bus.ram_oe_b    = !bus.cpu_rnw;
  assign bus.ram_data_oe = !bus.cpu_rnw && !bus.ext_cs_b;
  assign bus.ram_we_b    = we_b;

  // RAM address: CPU word address with the beat number as the low field.
  if (N == 1) begin : g_addr_single
    assign bus.ram_addr = bus.cpu_addr[RASIZE-1:0];
  end else begin : g_addr_multi
    assign bus.ram_addr = {bus.cpu_addr[RASIZE-LOG2N-1:0], beat};
  end

  // Select the write-data slice belonging to the current beat.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (beat == LOG2N'(i)) wdata = bus.cpu_dout[i*RSIZE +: RSIZE];
    end
  end
  assign bus.ram_data_out = wdata;

  // Capture on the last phase of each read beat; the final beat is only
  // registered when the read path is fully registered.
  assign capture = beat_end && (dir == ACC_READ) && !bus.ext_cs_b &&
                   ((REG_LAST != 0) || (beat != BEAT_LAST));

  // Read lanes hold their contents between accesses.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      for (int i = 0; i < N; i++) lane_q[i] <= '0;
    end else if (capture) begin
      lane_q[beat] <= bus.ram_data_in;
    end
  end

  // Assemble the CPU read word; the top slice bypasses the lanes unless the
  // final beat is registered.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N - 1; i++) rdata[i*RSIZE +: RSIZE] = lane_q[i];
    rdata[(N-1)*RSIZE +: RSIZE] = (REG_LAST != 0) ? lane_q[N-1] : bus.ram_data_in;
  end
  assign bus.ext_dout = rdata;

endmodule
